// File: rtl/cpu_v1_issue.sv
// ---------------------------------------------------------------------------
// cpu_v1_issue
//
// Multi-cycle fetch/decode/issue/writeback sequencer feeding the CPU v1 ALU.
// It fetches RV32I instruction words over a request/acknowledge port and
// decodes the supported ALU subset (R-type ADD/XOR/OR/AND, I-type
// ADDI/XORI/ORI/ANDI, LUI). It drives the ALU operands from a 32x32 register
// file plus immediates, and writes the ALU result back. Any other encoding
// parks the block in HALT until reset.
//
// Handshake: imem_req is high for every FETCH cycle with imem_addr == pc.
// The word on imem_data is taken on the rising edge where imem_ack is high,
// and only while in FETCH. There is no separate valid. imem_ack is the
// one-cycle "data valid" strobe. Acks seen in any other state are ignored.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   imem_addr/req   fetch address (== pc) and request (FETCH, not in reset)
//   imem_ack/data   fetch completion strobe and instruction word
//   alu_src_a/b/op  ALU operands and opcode (zero outside EXEC)
//   alu_res         combinational ALU result, written back at end of EXEC
//   retire          high during an EXEC cycle of a legal instruction
//   halt            sticky flag, set by an unsupported instruction
//   dbg_sel/data    register-file debug read port (x0 reads as 0)
//   dbg_state       current sequencer state (0 FETCH, 1 EXEC, 2 HALT)
// ---------------------------------------------------------------------------
module cpu_v1_issue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  output logic        imem_req,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  output logic [31:0] alu_src_a,
  output logic [31:0] alu_src_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_res,
  output logic        retire,
  output logic        halt,
  input  logic [4:0]  dbg_sel,
  output logic [31:0] dbg_data,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_EXEC  = 2'd1,
    S_HALT  = 2'd2
  } state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;

  // Architectural state
  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        halt_q, halt_d;
  // x0 is reset to zero and never written, so a plain read of entry 0
  // always yields 0 without any special casing on the read ports.
  logic [31:0] regs_q [32];

  // Instruction fields
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_u;
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;

  assign opcode  = ir_q[6:0];
  assign rd      = ir_q[11:7];
  assign funct3  = ir_q[14:12];
  assign rs1     = ir_q[19:15];
  assign rs2     = ir_q[24:20];
  assign funct7  = ir_q[31:25];
  assign imm_i   = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_u   = {ir_q[31:12], 12'b0};
  assign rs1_val = regs_q[rs1];
  assign rs2_val = regs_q[rs2];

  // Decode
  logic        f3_ok;
  logic [2:0]  f3_op;
  logic        legal;
  logic [31:0] dec_a;
  logic [31:0] dec_b;
  logic [2:0]  dec_op;

  // funct3 000 (add) is the only supported code whose ALU opcode differs
  // from funct3 itself; xor/or/and pass funct3 straight through.
  assign f3_ok = (funct3 == 3'b000) || (funct3 == 3'b100) ||
                 (funct3 == 3'b110) || (funct3 == 3'b111);
  assign f3_op = (funct3 == 3'b000) ? 3'b001 : funct3;

  always_comb begin
    legal  = 1'b0;
    dec_a  = 32'h0;
    dec_b  = 32'h0;
    dec_op = 3'b000;
    case (opcode)
      OPC_OP: begin
        if (f3_ok && (funct7 == 7'b0000000)) begin
          legal  = 1'b1;
          dec_a  = rs1_val;
          dec_b  = rs2_val;
          dec_op = f3_op;
        end
      end
      OPC_OP_IMM: begin
        if (f3_ok) begin
          legal  = 1'b1;
          dec_a  = rs1_val;
          dec_b  = imm_i;
          dec_op = f3_op;
        end
      end
      OPC_LUI: begin
        legal  = 1'b1;
        dec_a  = imm_u;
        dec_b  = 32'h0;
        dec_op = 3'b000;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  logic in_exec;
  logic rf_we;

  assign in_exec = (state_q == S_EXEC);
  // Write happens on the edge that ends EXEC, so same-instruction reads of
  // rd (rd == rs1/rs2) still see the old value during EXEC.
  assign rf_we   = in_exec && legal && (rd != 5'd0);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    halt_d  = halt_q;
    case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_data;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (legal) begin
          pc_d    = pc_q + 32'd4;  // wraps modulo 2^32
          state_d = S_FETCH;
        end else begin
          halt_d  = 1'b1;
          state_d = S_HALT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State registers and register file
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      halt_q  <= 1'b0;
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      halt_q  <= halt_d;
      if (rf_we) begin
        regs_q[rd] <= alu_res;
      end
    end
  end

  // Outputs
  assign imem_addr = pc_q;
  assign imem_req  = (state_q == S_FETCH) && !rst;
  assign alu_src_a = in_exec ? dec_a  : 32'h0;
  assign alu_src_b = in_exec ? dec_b  : 32'h0;
  assign alu_op    = in_exec ? dec_op : 3'b000;
  assign retire    = in_exec && legal && !rst;
  assign halt      = halt_q;
  assign dbg_data  = regs_q[dbg_sel];
  assign dbg_state = state_q;

endmodule

// File: doc/cpu_v1_issue.md
# cpu_v1_issue

Multi-cycle fetch/decode/issue/writeback sequencer that sits directly upstream of the CPU v1 ALU. It fetches 32-bit RV32I instructions over a request/acknowledge port and decodes the supported ALU subset. It drives the ALU operands and operation code from a 32x32 register file plus immediates, then writes the ALU result back to the register file. It owns the PC and halts on any unsupported encoding.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- imem_addr  out  32  fetch address, always equal to PC
- imem_req  out  1  fetch request; high in FETCH state, forced 0 while rst=1
- imem_ack  in  1  fetch complete; imem_data valid in this cycle only
- imem_data  in  32  instruction word
- alu_src_a  out  32  ALU operand A
- alu_src_b  out  32  ALU operand B
- alu_op  out  3  ALU op: 001 add, 100 xor, 110 or, 111 and, 000 pass src_a
- alu_res  in  32  ALU result (combinational from the three outputs above)
- retire  out  1  one-cycle pulse when an instruction writes back
- halt  out  1  sticky, set on unsupported instruction
- dbg_sel  in  5  register-file debug read index
- dbg_data  out  32  combinational read of x[dbg_sel]; returns 0 for x0

## Operation
- States: FETCH, EXEC, HALT. Reset state is FETCH.
- Reset values: pc=RESET_PC, ir=0, x1..x31=0, retire=0, halt=0, alu_op=000, alu_src_a=0, alu_src_b=0.
- FETCH: imem_req=1, imem_addr=pc. On an edge with imem_ack=1, ir<=imem_data and the state moves to EXEC. Otherwise the state stays in FETCH with the address held.
- EXEC: decode ir combinationally and drive the ALU.
  - If the instruction is legal:
    - x[rd]<=alu_res at the edge, except that writes to rd=0 are discarded.
    - pc<=pc+4.
    - retire=1 during this cycle.
    - Next state is FETCH.
  - If the instruction is illegal: halt<=1, pc is unchanged, no write, next state is HALT.
- HALT: imem_req=0, retire=0, ALU outputs at reset values. The block leaves HALT only through rst.
- Supported encodings. Anything else, including EBREAK and 0x00000000, is illegal.
  - R-type, opcode 0110011, funct7=0000000, funct3 in {000,100,110,111}:
    - src_a=x[rs1], src_b=x[rs2].
    - op: 001 for funct3 000; otherwise op=funct3.
  - I-type, opcode 0010011, funct3 in {000,100,110,111}:
    - src_a=x[rs1], src_b=sign-extended ir[31:20].
    - op mapping is the same as R-type.
  - LUI, opcode 0110111: src_a={ir[31:12],12'b0}, src_b=0, op=000.
- Outside EXEC, the ALU outputs are 0/0/000.
- Register reads see the pre-write value when rd equals rs1 or rs2 (write occurs at the end of EXEC).
- Arithmetic is 32-bit modulo 2^32, with no flags. PC+4 wraps 0xFFFFFFFC -> 0x00000000.

## Timing
- Minimum 2 cycles per instruction: 1 FETCH cycle with same-cycle ack, plus 1 EXEC cycle. Each cycle of ack delay adds 1 cycle.
- The ALU output path is combinational from ir and the register file in EXEC. The result is captured on the same edge that ends EXEC.
- imem_ack outside FETCH is ignored. imem_data is sampled only on the ack edge.
- rst asserted in any state, including mid-fetch with imem_ack=1 in the same cycle: reset wins, ir is not loaded, and the next cycle is FETCH at RESET_PC with imem_req=1.
- dbg_data reflects a write starting from the cycle after EXEC.

## Test plan
- Reset: hold rst 2 cycles, then release -> imem_req=1, imem_addr=0, halt=0, retire=0, dbg_data=0 for all dbg_sel.
- ADDI x1,x0,5 (0x00500093) then ADDI x2,x1,-3 (0xFFD08113), both acked in the same cycle:
  - Second EXEC shows src_a=5, src_b=0xFFFFFFFD, op=001.
  - x2=2, retire pulses twice, and pc=8 after 4 cycles.
- With x1=0x0F0F0F0F and x2=0x00FF00FF, run XOR x3,x1,x2 (0x0020C1B3), OR x4 (0x0020E233), AND x5 (0x0020F2B3):
  - ops 100/110/111.
  - x3=0x0FF00FF0, x4=0x0FFF0FFF, x5=0x000F000F.
- LUI x6,0x12345 (0x12345337) -> op=000, src_a=0x12345000, src_b=0, x6=0x12345000.
- ADDI x0,x0,7 (0x00700013) -> retire=1 but dbg x0=0. A following ADD x7,x0,x0 (0x000003B3) shows src_a=src_b=0.
- Ack delayed 3 cycles -> imem_req and imem_addr held stable for 4 cycles. Then illegal 0x00000000:
  - halt=1, no retire, pc unchanged, imem_req=0 thereafter.
  - Asserting rst clears halt and refetches RESET_PC.
